alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_core.sv | 35 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants and FSM state encoding for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_RED = 3'b110;
    localparam logic [2:0] OP_UND = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU operating on the arbiter's captured operands.
// Macro ALU_ARB_REDUCE_EN enables the reduction-OR opcode; otherwise it yields zero.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    // Opcode decode; ADD and SUB wrap modulo 2^WIDTH by truncation
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_NOT: y = ~a;
            OP_RED: begin
`ifdef ALU_ARB_REDUCE_EN
                y = {{(WIDTH-1){1'b0}}, |a};
`else
                y = {WIDTH{1'b0}};
`endif
            end
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU: accept, execute, hold the
// response until consumed. Build option: ALU_ARB_REDUCE_EN (see alu_core).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    input  logic             rsp_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_zero;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [WIDTH-1:0] w_y;

    // Grant selection: a tie goes to the requester that did not win last time
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && (r_state == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                if (r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture on accept; the ALU sees only these registers afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
            r_op   <= 3'b000;
            r_a    <= {WIDTH{1'b0}};
            r_b    <= {WIDTH{1'b0}};
            r_id   <= 1'b0;
        end else if (w_accept) begin
            r_last <= w_gnt1;
            r_id   <= w_gnt1;
            r_op   <= w_gnt1 ? req1_op : req0_op;
            r_a    <= w_gnt1 ? req1_a  : req0_a;
            r_b    <= w_gnt1 ? req1_b  : req0_b;
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .y  (w_y)
    );

    // Response registers: loaded in EXEC, held through RESP until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= {WIDTH{1'b0}};
            r_rsp_zero  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_y     <= w_y;
            r_rsp_zero  <= (w_y == {WIDTH{1'b0}});
        end else if ((r_state == ST_RESP) && r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences, random traffic.
module tb_alu_arbiter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_zero, rsp_ready;
    logic [W-1:0] rsp_y;

    int checks   = 0;
    int failures = 0;
    int tb_last  = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_zero   (rsp_zero),
        .rsp_ready  (rsp_ready)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table
    function automatic int model_y(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return (a + b) % MOD;
            4: return (a - b + MOD) % MOD;
            5: return MOD - 1 - a;
`ifdef ALU_ARB_REDUCE_EN
            6: return (a != 0) ? 1 : 0;
`else
            6: return 0;
`endif
            default: return 0;
        endcase
    endfunction

    // One transaction from an IDLE cycle; called at posedge+1, returns at posedge+1 in IDLE
    task automatic transact(input logic v0, input logic v1,
                            input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input int bp, output int got_id, output int got_y, output int got_z);
        int g, ey, ez;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = (bp == 0);
        got_id = -1; got_y = -1; got_z = -1;
        if (!v0 && !v1) begin
            #1;
            chk("idle_ready0", int'(req0_ready), 0);
            chk("idle_ready1", int'(req1_ready), 0);
            @(posedge clk); #1;
            return;
        end
        g  = (v0 && v1) ? ((tb_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
        ey = (g == 0) ? model_y(int'(op0), int'(a0), int'(b0)) : model_y(int'(op1), int'(a1), int'(b1));
        ez = (ey == 0) ? 1 : 0;
        #1;
        chk("grant_ready0", int'(req0_ready), (g == 0) ? 1 : 0);
        chk("grant_ready1", int'(req1_ready), (g == 1) ? 1 : 0);
        @(posedge clk); #1;
        tb_last = g;
        req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
        req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
        #1;
        chk("exec_ready0", int'(req0_ready), 0);
        chk("exec_ready1", int'(req1_ready), 0);
        chk("exec_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_id", int'(rsp_id), g);
        chk("rsp_y", int'(rsp_y), ey);
        chk("rsp_zero", int'(rsp_zero), ez);
        got_id = int'(rsp_id); got_y = int'(rsp_y); got_z = int'(rsp_zero);
        for (int k = 1; k < bp; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_id", int'(rsp_id), g);
            chk("hold_y", int'(rsp_y), ey);
            chk("hold_zero", int'(rsp_zero), ez);
            chk("hold_ready0", int'(req0_ready), 0);
            chk("hold_ready1", int'(req1_ready), 0);
        end
        if (bp > 0) rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_drop", int'(rsp_valid), 0);
    endtask

    typedef struct {
        int         rq;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         y;
        int         z;
        int         bp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int gid, gy, gz, v0, v1, bp;
        logic [2:0] o0, o1;
        logic [3:0] xa0, xb0, xa1, xb1;

        vecs[0] = '{0, 3'b001, 4'b1010, 4'b0101, 15, 0, 0};
        vecs[1] = '{1, 3'b000, 4'b1100, 4'b1010,  8, 0, 0};
        vecs[2] = '{0, 3'b010, 4'b1100, 4'b1010,  6, 0, 0};
        vecs[3] = '{1, 3'b011, 4'b1111, 4'b0001,  0, 1, 0};
        vecs[4] = '{0, 3'b100, 4'b0000, 4'b0001, 15, 0, 5};
        vecs[5] = '{1, 3'b101, 4'b0101, 4'b0011, 10, 0, 0};
        vecs[6] = '{0, 3'b111, 4'b1111, 4'b1111,  0, 1, 0};
`ifdef ALU_ARB_REDUCE_EN
        vecs[7] = '{1, 3'b110, 4'b0100, 4'b0000,  1, 0, 0};
`else
        vecs[7] = '{1, 3'b110, 4'b0100, 4'b0000,  0, 1, 0};
`endif
        vecs[8] = '{0, 3'b011, 4'b0111, 4'b0110, 13, 0, 2};

        // Reset with both requesters asserting: nothing may be granted
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'b1010; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'b0000; req1_b = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_ready0", int'(req0_ready), 0);
            chk("rst_ready1", int'(req1_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_rsp_y", int'(rsp_y), 0);
            chk("rst_rsp_zero", int'(rsp_zero), 0);
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tb_last = 1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rq == 0)
                transact(1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 3'b000, 4'b0000, 4'b0000,
                         vecs[i].bp, gid, gy, gz);
            else
                transact(1'b0, 1'b1, 3'b000, 4'b0000, 4'b0000, vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].bp, gid, gy, gz);
            chk($sformatf("vec%0d_id", i), gid, vecs[i].rq);
            chk($sformatf("vec%0d_y", i), gy, vecs[i].y);
            chk($sformatf("vec%0d_zero", i), gz, vecs[i].z);
        end

        // Contention after a fresh reset: req0, req1, req0, req1
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tb_last = 1;
        for (int i = 0; i < 4; i++) begin
            transact(1'b1, 1'b1, 3'b011, 4'(i), 4'b0001, 3'b010, 4'(i), 4'b1111, 0, gid, gy, gz);
            chk($sformatf("rr_order%0d", i), gid, i % 2);
        end

        // Reset during EXEC: req0 wins last, reset must restore req0 priority
        transact(1'b1, 1'b0, 3'b001, 4'b0011, 4'b0000, 3'b000, 4'b0000, 4'b0000, 0, gid, gy, gz);
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 4'b0001; req0_b = 4'b0001;
        req1_valid = 1'b0;
        #1;
        chk("mid_accept", int'(req0_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        chk("mid_rst_ready0", int'(req0_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rsp_valid_a", int'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("mid_rsp_valid_b", int'(rsp_valid), 0);
        tb_last = 1;
        transact(1'b1, 1'b1, 3'b000, 4'b1111, 4'b0110, 3'b001, 4'b0000, 4'b0000, 0, gid, gy, gz);
        chk("mid_tie_to_req0", gid, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            v0 = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
            o0 = 3'($urandom); o1 = 3'($urandom);
            xa0 = 4'($urandom); xb0 = 4'($urandom); xa1 = 4'($urandom); xb1 = 4'($urandom);
            bp = $urandom_range(0, 3);
            transact(v0[0], v1[0], o0, xa0, xb0, o1, xa1, xb1, bp, gid, gy, gz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
